// File: rtl/adder_pkg.sv
// Shared constants and types for the pipelined add/subtract unit.
package adder_pkg;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  // Per-stage control bundle: occupancy flag plus the carry handed to the next slice.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

  function automatic int num_chunks(input int bus_w, input int chunk_w);
    return bus_w / chunk_w;
  endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// One ripple-carry slice; also exposes the carry into its MSB so the top
// can form signed overflow on the most significant slice.
module add_sub_chunk
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [WIDTH:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[WIDTH];
  assign cmsb = carry[WIDTH-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement add/subtract, one register stage per CHUNK_WIDTH slice,
// elastic valid/ready handshake. Define PIPE_ADDER_SAT_EN to saturate on signed overflow.
module pipelined_add_sub
  import adder_pkg::*;
#(
  parameter int BUS_WIDTH   = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 add_sub_b,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 ovf,
  output logic                 cout
);

  localparam int NC = num_chunks(BUS_WIDTH, CHUNK_WIDTH);

  if (BUS_WIDTH % CHUNK_WIDTH != 0) begin : g_width_check
    $error("BUS_WIDTH must be an integer multiple of CHUNK_WIDTH");
  end

  stage_ctrl_t            ctrl_q [NC];
  logic [BUS_WIDTH-1:0]   a_q    [NC];
  logic [BUS_WIDTH-1:0]   b_q    [NC];
  logic [BUS_WIDTH-1:0]   s_q    [NC];
  logic                   ovf_q;

  logic                   v_d    [NC];
  logic                   c_d    [NC];
  logic [BUS_WIDTH-1:0]   a_d    [NC];
  logic [BUS_WIDTH-1:0]   b_d    [NC];
  logic [BUS_WIDTH-1:0]   s_d    [NC];
  logic [BUS_WIDTH-1:0]   s_nxt  [NC];
  logic [CHUNK_WIDTH-1:0] sum_w  [NC];
  logic                   cout_w [NC];
  logic                   cmsb_w [NC];

  logic [NC-1:0]          free;
  logic                   free_next;
  logic [BUS_WIDTH-1:0]   out_d;
  logic                   ovf_d;

  // A stage may load when empty or when everything downstream of it moves this cycle.
  always_comb begin
    free      = '0;
    free_next = out_ready;
    for (int k = NC - 1; k >= 0; k--) begin
      free[k]   = !ctrl_q[k].valid || free_next;
      free_next = free[k];
    end
  end

  assign in_ready = rst_b & free[0];

  for (genvar g = 0; g < NC; g++) begin : g_stage
    if (g == 0) begin : g_head
      // Subtraction is in1 + ~in2 + 1; the +1 enters as the slice-0 carry-in.
      assign v_d[0] = in_valid;
      assign a_d[0] = in1;
      assign b_d[0] = (add_sub_b == OP_ADD) ? in2 : ~in2;
      assign c_d[0] = (add_sub_b == OP_SUB);
      assign s_d[0] = '0;
    end else begin : g_body
      assign v_d[g] = ctrl_q[g-1].valid;
      assign a_d[g] = a_q[g-1];
      assign b_d[g] = b_q[g-1];
      assign c_d[g] = ctrl_q[g-1].carry;
      assign s_d[g] = s_q[g-1];
    end

    add_sub_chunk #(.WIDTH(CHUNK_WIDTH)) u_chunk (
      .a    (a_d[g][g*CHUNK_WIDTH +: CHUNK_WIDTH]),
      .b    (b_d[g][g*CHUNK_WIDTH +: CHUNK_WIDTH]),
      .cin  (c_d[g]),
      .sum  (sum_w[g]),
      .cout (cout_w[g]),
      .cmsb (cmsb_w[g])
    );

    // Upper result slices are still zero here, so OR-ing the new slice in is enough.
    assign s_nxt[g] = s_d[g] | (BUS_WIDTH'(sum_w[g]) << (g * CHUNK_WIDTH));
  end

  assign ovf_d = cmsb_w[NC-1] ^ cout_w[NC-1];

  // Overflow implies both effective operand signs agree, so in1's sign picks the rail.
  always_comb begin
    out_d = s_nxt[NC-1];
`ifdef PIPE_ADDER_SAT_EN
    if (ovf_d) begin
      out_d = a_d[NC-1][BUS_WIDTH-1] ? {1'b1, {(BUS_WIDTH-1){1'b0}}}
                                     : {1'b0, {(BUS_WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int k = 0; k < NC; k++) begin
        ctrl_q[k] <= '0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        s_q[k]    <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (free[k]) begin
          ctrl_q[k].valid <= v_d[k];
          if (v_d[k]) begin
            ctrl_q[k].carry <= cout_w[k];
            a_q[k]          <= a_d[k];
            b_q[k]          <= b_d[k];
            s_q[k]          <= (k == NC - 1) ? out_d : s_nxt[k];
          end
        end
      end
      if (free[NC-1] && v_d[NC-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = ctrl_q[NC-1].valid;
  assign out       = s_q[NC-1];
  assign cout      = ctrl_q[NC-1].carry;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub (32-bit, 8-bit slices, latency 4).
// Expected values follow PIPE_ADDER_SAT_EN when it is defined for the build.
module tb_pipelined_add_sub;

  typedef struct {
    logic [31:0] out;
    logic        ovf;
    logic        cout;
    bit          chk_lat;
    int          accept_edge;
  } exp_t;

  logic        clk;
  logic        rst_b;
  logic        in_valid;
  logic        in_ready;
  logic        add_sub_b;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        ovf;
  logic        cout;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          stream_done = 0;
  bit          held = 0;
  logic [31:0] held_out;
  logic        held_ovf;
  logic        held_cout;

  pipelined_add_sub #(.BUS_WIDTH(32), .CHUNK_WIDTH(8)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .add_sub_b (add_sub_b),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .ovf       (ovf),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] o, input logic v, input logic c, input bit lat);
    exp_t e;
    e.out = o;
    e.ovf = v;
    e.cout = c;
    e.chk_lat = lat;
    e.accept_edge = 0;
    return e;
  endfunction

  // Reference: 33-bit sum of in1 and the effective second operand.
  function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] be;
    logic [32:0] s;
    exp_t        e;
    be = op ? b : ~b;
    s = {1'b0, a} + {1'b0, be} + 33'(!op);
    e = mk(s[31:0], (a[31] == be[31]) && (s[31] != a[31]), s[32], 1'b0);
`ifdef PIPE_ADDER_SAT_EN
    if (e.ovf) e.out = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return e;
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic apply_stimulus(input logic op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int waited = 0;
    bit done = 0;
    in_valid = 1'b1;
    add_sub_b = op;
    in1 = a;
    in2 = b;
    while (!done && waited < 200) begin
      @(negedge clk);
      if (in_ready) begin
        e.accept_edge = cyc + 1;
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got=no_accept expected=accept");
    end
  endtask

  task automatic apply_model(input logic op, input logic [31:0] a, input logic [31:0] b);
    apply_stimulus(op, a, b, model(op, a, b));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_output("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: occupancy rule for in_ready, output stability under stall, in-order scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_b) begin
      held = 0;
    end else begin
      if (!in_ready) begin
        check_output("inready_low_occupancy", 32'(sb.size()), 32'd4);
        check_output("inready_low_out_ready", 32'(out_ready), 32'd0);
      end
      if (held) begin
        check_output("hold_out", out, held_out);
        check_output("hold_ovf", 32'(ovf), 32'(held_ovf));
        check_output("hold_cout", 32'(cout), 32'(held_cout));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_output: got=%h expected=none", out);
        end else begin
          e = sb.pop_front();
          check_output("out", out, e.out);
          check_output("ovf", 32'(ovf), 32'(e.ovf));
          check_output("cout", 32'(cout), 32'(e.cout));
          if (e.chk_lat) check_output("latency", 32'(cyc + 1 - e.accept_edge), 32'd4);
        end
      end
      held = out_valid && !out_ready;
      held_out = out;
      held_ovf = ovf;
      held_cout = cout;
    end
  end

  initial begin : stimulus
    int seen;
    rst_b = 1'b0;
    in_valid = 1'b0;
    add_sub_b = 1'b1;
    in1 = '0;
    in2 = '0;
    out_ready = 1'b1;
    #2;
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_in_ready", 32'(in_ready), 32'd0);
    check_output("reset_out", out, 32'd0);
    check_output("reset_ovf", 32'(ovf), 32'd0);
    check_output("reset_cout", 32'(cout), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_b = 1'b1;
    @(posedge clk);
    #1;

    // Isolated directed ops, each checked for latency.
    apply_stimulus(1'b1, 32'd110, 32'd24, mk(32'd134, 1'b0, 1'b0, 1'b1));
    wait_drain();
    apply_stimulus(1'b0, 32'd24, 32'd110, mk(32'hFFFF_FFAA, 1'b0, 1'b0, 1'b1));
    wait_drain();
    apply_stimulus(1'b0, 32'd110, 32'd24, mk(32'd86, 1'b0, 1'b1, 1'b1));
    wait_drain();
`ifdef PIPE_ADDER_SAT_EN
    apply_stimulus(1'b1, 32'h7FFF_FFFF, 32'd1, mk(32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1));
    wait_drain();
    apply_stimulus(1'b0, 32'h8000_0000, 32'd1, mk(32'h8000_0000, 1'b1, 1'b1, 1'b1));
    wait_drain();
    apply_stimulus(1'b1, 32'h8000_0000, 32'h8000_0000, mk(32'h8000_0000, 1'b1, 1'b1, 1'b1));
`else
    apply_stimulus(1'b1, 32'h7FFF_FFFF, 32'd1, mk(32'h8000_0000, 1'b1, 1'b0, 1'b1));
    wait_drain();
    apply_stimulus(1'b0, 32'h8000_0000, 32'd1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1));
    wait_drain();
    apply_stimulus(1'b1, 32'h8000_0000, 32'h8000_0000, mk(32'h0000_0000, 1'b1, 1'b1, 1'b1));
`endif
    wait_drain();
    apply_stimulus(1'b1, 32'hFFFF_FFFF, 32'd1, mk(32'h0000_0000, 1'b0, 1'b1, 1'b1));
    wait_drain();
    apply_stimulus(1'b0, 32'd0, 32'd0, mk(32'h0000_0000, 1'b0, 1'b1, 1'b1));
    wait_drain();

    // Back-to-back throughput.
    apply_stimulus(1'b1, 32'h0000_00FF, 32'h0000_0001, mk(32'h0000_0100, 1'b0, 1'b0, 1'b0));
    apply_stimulus(1'b1, 32'h00FF_FFFF, 32'h0000_0001, mk(32'h0100_0000, 1'b0, 1'b0, 1'b0));
    apply_stimulus(1'b0, 32'h1000_0000, 32'h0000_0001, mk(32'h0FFF_FFFF, 1'b0, 1'b1, 1'b0));
    wait_drain();

    // Backpressure: fill to four, fifth waits, then drain while accepting.
    out_ready = 1'b0;
    apply_model(1'b1, 32'd1, 32'd2);
    apply_model(1'b0, 32'd5, 32'd7);
    apply_model(1'b1, 32'h1234_5678, 32'h1111_1111);
    apply_model(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    fork
      apply_model(1'b1, 32'hFFFF_0000, 32'h0001_0000);
      begin
        idle(6);
        check_output("full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Random stream with random gaps and random consumer stalls.
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          logic        op;
          logic [31:0] a;
          logic [31:0] b;
          op = 1'($urandom_range(0, 1));
          a = $urandom;
          b = $urandom;
          if (i == 5) begin
            op = 1'b1;
            a = 32'h7FFF_FFF0;
            b = 32'h0000_0100;
          end
          apply_model(op, a, b);
          idle($urandom_range(0, 2));
        end
        stream_done = 1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #2;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Async reset with three ops in flight.
    out_ready = 1'b0;
    apply_model(1'b1, 32'd10, 32'd20);
    apply_model(1'b1, 32'd30, 32'd40);
    apply_model(1'b0, 32'd50, 32'd60);
    seen = 0;
    for (int i = 0; i < 12 && seen == 0; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check_output("inflight_valid_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #3 rst_b = 1'b0;
    sb.delete();
    #1;
    check_output("async_out_valid", 32'(out_valid), 32'd0);
    check_output("async_in_ready", 32'(in_ready), 32'd0);
    check_output("async_out", out, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_b = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_output("stale_after_reset", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 32'd1000, 32'd234, mk(32'd1234, 1'b0, 1'b0, 1'b1));
    wait_drain();

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
